reg_file: RTL and testbench

Eight-entry, 16-bit, two-read/one-write register file for the simple processor datapath. Register 0 is not storage: selecting it on a read port forwards the external data input DIN. Registers 1–7 are loaded from RIN on the clock edge. The block sits between the datapath buses and the ALU operand inputs: ABUS is the A operand and BBUS is the B operand.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/reg_file_if.sv | 30 +++
 rtl/regfile_rdport.sv | 25 ++
 rtl/reg_file.sv | 51 +++++
 tb/tb_reg_file.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file.
//   WIDTH  : data width of every bus and register
//   NREGS  : number of select addresses, including the non-storage address 0
//   SEL_W  : select width, log2(NREGS)
//   data_t : one data word
//   sel_t  : one register select
//   regs_t : packed storage r1..r(NREGS-1); index 0 intentionally absent
package regfile_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREGS = 8;
    localparam int unsigned SEL_W = $clog2(NREGS);

    typedef logic [WIDTH-1:0] data_t;
    typedef logic [SEL_W-1:0] sel_t;
    typedef data_t [NREGS-1:1] regs_t;

endpackage

// File: rtl/reg_file_if.sv
// Datapath-side bus of the register file.
//   dsel : write destination select (0 = no write)
//   asel : A read-port select
//   bsel : B read-port select
//   din  : external data, forwarded when a read select is 0
//   rin  : write data
//   abus : A operand read data (combinational)
//   bbus : B operand read data (combinational)
// master drives selects and data; slave (the register file) returns the read buses.
interface reg_file_if;

    regfile_pkg::sel_t  dsel;
    regfile_pkg::sel_t  asel;
    regfile_pkg::sel_t  bsel;
    regfile_pkg::data_t din;
    regfile_pkg::data_t rin;
    regfile_pkg::data_t abus;
    regfile_pkg::data_t bbus;

    modport master (
        output dsel, asel, bsel, din, rin,
        input  abus, bbus
    );

    modport slave (
        input  dsel, asel, bsel, din, rin,
        output abus, bbus
    );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port.
//   sel_i  : register select; 0 forwards din_i
//   din_i  : external data
//   regs_i : stored registers r1..r(NREGS-1)
//   data_o : selected data
module regfile_rdport
    import regfile_pkg::*;
(
    input  sel_t  sel_i,
    input  data_t din_i,
    input  regs_t regs_i,
    output data_t data_o
);

    // Loop compare keeps every index in range; address 0 falls through to din_i.
    always_comb begin
        data_o = din_i;
        for (int i = 1; i < int'(NREGS); i++) begin
            if (sel_i == sel_t'(i)) begin
                data_o = regs_i[i];
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file feeding the ALU operands.
//   clk_i  : clock, all state updates on the rising edge
//   rst_i  : synchronous active-high reset, clears r1..r7
//   bus_io : slave side of reg_file_if (selects, din/rin in; abus/bbus out)
// Address 0 is not storage: reading it forwards din, writing it is a no-op.
// No write-through bypass: a register being written reads its old value until the edge.
module reg_file
    import regfile_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    reg_file_if.slave  bus_io
);

    regs_t regs_q;
    regs_t regs_d;

    // Write decode: at most one register takes rin; dsel = 0 matches nothing.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < int'(NREGS); i++) begin
            if (bus_io.dsel == sel_t'(i)) begin
                regs_d[i] = bus_io.rin;
            end
        end
    end

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rdport u_rdport_a (
        .sel_i  (bus_io.asel),
        .din_i  (bus_io.din),
        .regs_i (regs_q),
        .data_o (bus_io.abus)
    );

    regfile_rdport u_rdport_b (
        .sel_i  (bus_io.bsel),
        .din_i  (bus_io.din),
        .regs_i (regs_q),
        .data_o (bus_io.bbus)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: an array model of r1..r7 checked every
// negative edge, plus directed literal expectations from the test plan.
module tb_reg_file;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [15:0] model [1:7];

    reg_file_if rf ();

    reg_file dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (rf.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an array written on the edge, reset clears it, select 0 is DIN.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 7; i++) model[i] <= 16'h0;
        end else if (rf.dsel != 3'd0) begin
            model[rf.dsel] <= rf.rin;
        end
    end

    function automatic logic [15:0] expect_rd(input logic [2:0] sel, input logic [15:0] din);
        return (sel == 3'd0) ? din : model[sel];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("abus_model", rf.abus, expect_rd(rf.asel, rf.din));
            check("bbus_model", rf.bbus, expect_rd(rf.bsel, rf.din));
        end
    end

    // Drive a new input set just after a rising edge.
    task automatic step(input logic r, input logic [2:0] d, input logic [2:0] a,
                        input logic [2:0] b, input logic [15:0] di, input logic [15:0] ri);
        @(posedge clk);
        #1;
        rst     = r;
        rf.dsel = d;
        rf.asel = a;
        rf.bsel = b;
        rf.din  = di;
        rf.rin  = ri;
        #1;
    endtask

    initial begin
        rf.dsel = 3'd0;
        rf.asel = 3'd0;
        rf.bsel = 3'd0;
        rf.din  = 16'h0;
        rf.rin  = 16'h0;

        // Reset for two edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 3'd0, 3'(k), 3'd0, 16'h0, 16'h0);
            check("reset_abus", rf.abus, 16'h0);
        end
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 3'd0, 3'd0, 3'(k), 16'h0, 16'h0);
            check("reset_bbus", rf.bbus, 16'h0);
        end

        // Write rk <= k.
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 3'(k), 3'd0, 3'd0, 16'h0, 16'(k));
        end
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 3'd0, 3'(k), 3'd0, 16'h0, 16'h0);
            check("readback_a", rf.abus, 16'(k));
            check("readback_a_b0", rf.bbus, 16'h0);
        end
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 3'd0, 3'd0, 3'(k), 16'h0, 16'h0);
            check("readback_b", rf.bbus, 16'(k));
            check("readback_b_a0", rf.abus, 16'h0);
        end

        // Forwarding with DSEL=0: nothing stored.
        step(1'b0, 3'd0, 3'd0, 3'd0, 16'd15, 16'd10);
        check("fwd_abus", rf.abus, 16'd15);
        check("fwd_bbus", rf.bbus, 16'd15);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 3'd0, 3'(k), 3'(k), 16'h0, 16'h0);
            check("fwd_nochange_a", rf.abus, 16'(k));
            check("fwd_nochange_b", rf.bbus, 16'(k));
        end

        // Randomised reads against the known contents rk = k.
        for (int n = 0; n < 20; n++) begin
            logic [2:0]  b;
            logic [15:0] di;
            b  = 3'($urandom_range(0, 7));
            di = 16'($urandom);
            step(1'b0, 3'd0, 3'd0, b, di, 16'($urandom));
            check("rand_abus", rf.abus, di);
            check("rand_bbus", rf.bbus, (b == 3'd0) ? di : 16'(b));
        end

        // Random traffic including occasional reset; the model checks every cycle.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 16'($urandom), 16'($urandom));
        end

        // Reset priority over a same-cycle write.
        step(1'b0, 3'd3, 3'd0, 3'd0, 16'h0, 16'h5A5A);
        step(1'b1, 3'd3, 3'd3, 3'd0, 16'h0, 16'hBEEF);
        step(1'b0, 3'd0, 3'd3, 3'd3, 16'h0, 16'h0);
        check("rst_prio_a", rf.abus, 16'h0);
        check("rst_prio_b", rf.bbus, 16'h0);

        // No bypass: old value before the edge, new value after.
        step(1'b0, 3'd2, 3'd0, 3'd0, 16'h0, 16'h0077);
        step(1'b0, 3'd2, 3'd2, 3'd0, 16'h0, 16'h1234);
        check("nobypass_before", rf.abus, 16'h0077);
        step(1'b0, 3'd0, 3'd2, 3'd0, 16'h0, 16'h0);
        check("nobypass_after", rf.abus, 16'h1234);

        // DIN tracks combinationally with zero latency.
        #1;
        rf.din = 16'hA5C3;
        #1;
        check("din_comb_b", rf.bbus, 16'hA5C3);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
